// File: rtl/eigen_sequencer_pkg.sv
// Shared types for the eigen_sequencer slice: engine-facing number formats,
// the sequencer state encoding and a small state-classification helper.
package fsm_eigen_sequencer;

   localparam int DOUBLE_W = 64;
   localparam int ITER_W   = 32;
   localparam int IDX_W    = 3;

   typedef logic [DOUBLE_W-1:0] fp_double_t;

   typedef enum logic [2:0] {
      IDLE_ES    = 3'd0,
      ENG_RST_ES = 3'd1,
      RUN_ES     = 3'd2,
      CAPTURE_ES = 3'd3,
      DEFLATE_ES = 3'd4,
      DONE_ES    = 3'd5,
      XXX_ES     = 3'd7
   } es_state_t;

   // Busy covers every state in which a sequence is in flight.
   function automatic logic es_is_busy(input es_state_t s);
      return (s != IDLE_ES) && (s != DONE_ES);
   endfunction

endpackage

// File: rtl/eigen_sequencer_watchdog.sv
// Per-run cycle watchdog: saturating up-counter with synchronous clear and
// an expired flag once the count reaches TIMEOUT-1.
module seq_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] ONE   = CW'(1'b1);

   logic [CW-1:0] count_r;

   // Count enabled cycles, holding at LIMIT so the flag can never wrap away.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (clear) begin
         count_r <= '0;
      end else if (enable && (count_r != LIMIT)) begin
         count_r <= count_r + ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LIMIT);

endmodule

// File: rtl/eigen_sequencer.sv
// Runs the shared eigenloop engine once per principal component, capturing each
// converged vector and handshaking with the deflation block between components.
module eigen_sequencer
   import fsm_eigen_sequencer::*;
#(
   parameter int SIZE_N   = 8,
   parameter int NUM_COMP = 2,
   parameter int TIMEOUT  = 4096
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [2*SIZE_N*DOUBLE_W-1:0]        seed_vectors,
   output logic                                eng_rst,
   output logic                                eng_start,
   output logic [2*SIZE_N*DOUBLE_W-1:0]        eng_vectors_in,
   input  logic [SIZE_N*DOUBLE_W-1:0]          eng_vector_out,
   input  logic [ITER_W-1:0]                   eng_k,
   input  logic                                eng_f,
   output logic                                defl_req,
   output logic [IDX_W-1:0]                    defl_idx,
   input  logic                                defl_ack,
   output logic [NUM_COMP*SIZE_N*DOUBLE_W-1:0] components,
   output logic [NUM_COMP*ITER_W-1:0]          comp_iters,
   output logic [NUM_COMP-1:0]                 comp_valid,
   output logic                                busy,
   output logic                                err,
   output logic                                f
);

   localparam int VEC_W = SIZE_N * DOUBLE_W;

   es_state_t                     state_r, next_state_s;
   logic [IDX_W-1:0]              comp_idx_r, defl_idx_r;
   logic                          eng_rst_r, eng_start_r, defl_req_r;
   logic                          busy_r, err_r, f_r;
   logic [NUM_COMP*VEC_W-1:0]     components_r;
   logic [NUM_COMP*ITER_W-1:0]    comp_iters_r;
   logic [NUM_COMP-1:0]           comp_valid_r;
   logic                          wd_clear_s, wd_enable_s, wd_expired_s;
   logic                          last_comp_s, defl_acc_s, new_run_s;

   assign wd_clear_s  = (state_r == ENG_RST_ES);
   assign wd_enable_s = (state_r == RUN_ES);
   assign last_comp_s = (comp_idx_r == IDX_W'(NUM_COMP - 1));
   assign defl_acc_s  = (state_r == DEFLATE_ES) && defl_req_r && defl_ack;
   assign new_run_s   = (state_r == IDLE_ES) && start;

   seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear_s),
      .enable  (wd_enable_s),
      .expired (wd_expired_s)
   );

   // Next-state logic; a finishing engine beats the watchdog in the same cycle.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE_ES:    if (start) next_state_s = ENG_RST_ES; else next_state_s = IDLE_ES;
         ENG_RST_ES: next_state_s = RUN_ES;
         RUN_ES: begin
            if (eng_f)             next_state_s = CAPTURE_ES;
            else if (wd_expired_s) next_state_s = DONE_ES;
            else                   next_state_s = RUN_ES;
         end
         CAPTURE_ES: if (last_comp_s) next_state_s = DONE_ES; else next_state_s = DEFLATE_ES;
         DEFLATE_ES: if (defl_acc_s) next_state_s = ENG_RST_ES; else next_state_s = DEFLATE_ES;
         DONE_ES:    if (!start) next_state_s = IDLE_ES; else next_state_s = DONE_ES;
         default:    next_state_s = IDLE_ES;
      endcase
   end

   // State register plus control outputs registered from the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE_ES;
         eng_rst_r   <= 1'b0;
         eng_start_r <= 1'b0;
         defl_req_r  <= 1'b0;
         busy_r      <= 1'b0;
         f_r         <= 1'b0;
         defl_idx_r  <= '0;
      end else begin
         state_r     <= next_state_s;
         eng_rst_r   <= (next_state_s == ENG_RST_ES);
         eng_start_r <= (next_state_s == RUN_ES);
         defl_req_r  <= (next_state_s == DEFLATE_ES);
         busy_r      <= es_is_busy(next_state_s);
         f_r         <= (next_state_s == DONE_ES);
         if (next_state_s == DEFLATE_ES) begin
            defl_idx_r <= comp_idx_r;
         end
      end
   end

   // Component index, error flag and capture storage; results persist across IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         comp_idx_r   <= '0;
         err_r        <= 1'b0;
         components_r <= '0;
         comp_iters_r <= '0;
         comp_valid_r <= '0;
      end else begin
         if (new_run_s) begin
            comp_idx_r   <= '0;
            err_r        <= 1'b0;
            comp_iters_r <= '0;
            comp_valid_r <= '0;
         end
         if ((state_r == RUN_ES) && !eng_f && wd_expired_s) begin
            err_r <= 1'b1;
         end
         if (defl_acc_s) begin
            comp_idx_r <= comp_idx_r + 3'd1;
         end
         for (int i = 0; i < NUM_COMP; i++) begin
            if ((state_r == CAPTURE_ES) && (comp_idx_r == IDX_W'(i))) begin
               components_r[i*VEC_W +: VEC_W]   <= eng_vector_out;
               comp_iters_r[i*ITER_W +: ITER_W] <= eng_k;
               comp_valid_r[i]                  <= 1'b1;
            end
         end
      end
   end

   assign eng_vectors_in = seed_vectors;
   assign eng_rst        = eng_rst_r;
   assign eng_start      = eng_start_r;
   assign defl_req       = defl_req_r;
   assign defl_idx       = defl_idx_r;
   assign components     = components_r;
   assign comp_iters     = comp_iters_r;
   assign comp_valid     = comp_valid_r;
   assign busy           = busy_r;
   assign err            = err_r;
   assign f              = f_r;

endmodule

// File: tb/tb_eigen_sequencer.sv
// Scoreboard bench for eigen_sequencer: stimulus pushes expected capture,
// deflation-request and completion events; a negedge monitor pops and compares.
module tb_eigen_sequencer;

   localparam int SIZE_N   = 4;
   localparam int NUM_COMP = 2;
   localparam int TIMEOUT  = 64;
   localparam int DW       = 64;
   localparam int VW       = SIZE_N * DW;
   localparam int CW       = NUM_COMP * VW;

   logic                   clk = 1'b0;
   logic                   rst, start, eng_rst, eng_start, eng_f, defl_req, defl_ack;
   logic                   busy, err, f;
   logic [2*VW-1:0]        seed_vectors, eng_vectors_in;
   logic [VW-1:0]          eng_vector_out;
   logic [31:0]            eng_k;
   logic [2:0]             defl_idx;
   logic [NUM_COMP*VW-1:0] components;
   logic [NUM_COMP*32-1:0] comp_iters;
   logic [NUM_COMP-1:0]    comp_valid;

   always #5 clk = ~clk;

   eigen_sequencer #(.SIZE_N(SIZE_N), .NUM_COMP(NUM_COMP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .seed_vectors(seed_vectors),
      .eng_rst(eng_rst), .eng_start(eng_start), .eng_vectors_in(eng_vectors_in),
      .eng_vector_out(eng_vector_out), .eng_k(eng_k), .eng_f(eng_f),
      .defl_req(defl_req), .defl_idx(defl_idx), .defl_ack(defl_ack),
      .components(components), .comp_iters(comp_iters), .comp_valid(comp_valid),
      .busy(busy), .err(err), .f(f)
   );

   // Engine model: finishes once it has been started for delay_cfg cycles.
   int run_cnt = 0;
   int delay_cfg = 1000;
   always @(posedge clk) begin
      if (eng_rst === 1'b1) run_cnt <= 0;
      else if (eng_start === 1'b1) run_cnt <= run_cnt + 1;
   end
   assign eng_f = (eng_start === 1'b1) && (run_cnt == delay_cfg);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_CAP = 0, EV_DEFL = 1, EV_DONE = 2} ev_kind_t;
   typedef struct {
      ev_kind_t            kind;
      int                  idx;
      logic [VW-1:0]       vec;
      logic [31:0]         k;
      logic                err;
      logic [NUM_COMP-1:0] valid;
      int                  cyc;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   function automatic ev_t mk(input ev_kind_t kd, input int idx, input logic [VW-1:0] v,
                              input logic [31:0] k, input logic e,
                              input logic [NUM_COMP-1:0] val, input int c);
      ev_t r;
      r.kind = kd; r.idx = idx; r.vec = v; r.k = k; r.err = e; r.valid = val; r.cyc = c;
      return r;
   endfunction

   function automatic logic [VW-1:0] mkvec(input logic [15:0] tag);
      logic [VW-1:0] v;
      for (int j = 0; j < SIZE_N; j++) v[j*DW +: DW] = {tag, 16'h3ff0, 16'(j), 16'h5a5a};
      return v;
   endfunction

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic score(input ev_t o);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: got kind=%0d idx=%0d at cycle %0d, required no event",
                  o.kind, o.idx, o.cyc);
         return;
      end
      e = exp_q.pop_front();
      if (o.kind == e.kind && o.idx == e.idx && o.vec === e.vec && o.k === e.k &&
          o.err === e.err && o.valid === e.valid && o.cyc == e.cyc) begin
         n_pass++;
      end else begin
         $display("FAIL event: got kind=%0d idx=%0d cyc=%0d k=%0d err=%b valid=%b vec=%0h, required kind=%0d idx=%0d cyc=%0d k=%0d err=%b valid=%b vec=%0h",
                  o.kind, o.idx, o.cyc, o.k, o.err, o.valid, o.vec,
                  e.kind, e.idx, e.cyc, e.k, e.err, e.valid, e.vec);
      end
   endtask

   // Monitor: turn rising capture/request/done indications into events.
   logic [NUM_COMP-1:0] valid_prev = '0;
   logic                defl_prev  = 1'b0;
   logic                f_prev     = 1'b0;
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int i = 0; i < NUM_COMP; i++) begin
            if (comp_valid[i] === 1'b1 && valid_prev[i] !== 1'b1)
               score(mk(EV_CAP, i, components[i*VW +: VW], comp_iters[i*32 +: 32], 1'b0, '0, cyc));
         end
         if (defl_req === 1'b1 && defl_prev !== 1'b1)
            score(mk(EV_DEFL, int'(defl_idx), '0, 32'd0, 1'b0, '0, cyc));
         if (f === 1'b1 && f_prev !== 1'b1)
            score(mk(EV_DONE, 0, '0, 32'd0, err, comp_valid, cyc));
      end
      valid_prev = comp_valid;
      defl_prev  = defl_req;
      f_prev     = f;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int i = 0;
      while (exp_q.size() != 0 && i < budget) begin
         step(1);
         i++;
      end
      step(1);
      check(name, CW'(exp_q.size()), '0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctrl"}, CW'({eng_rst, eng_start, defl_req, defl_idx, comp_valid, busy, err, f}), '0);
      check({name, "_components"}, components, '0);
      check({name, "_iters"}, CW'(comp_iters), '0);
   endtask

   logic [VW-1:0] vec_a, vec_b, vec_c, vec_d;
   int            n, d;
   logic          stall_ok;

   initial begin
      vec_a = mkvec(16'h000a); vec_b = mkvec(16'h000b);
      vec_c = mkvec(16'h000c); vec_d = mkvec(16'h000d);
      rst = 1'b1; start = 1'b0; defl_ack = 1'b0; eng_k = 32'd0; eng_vector_out = '0;
      seed_vectors = {mkvec(16'h5eed), mkvec(16'h0001)};
      step(3);
      check_all_zero("reset");
      rst = 1'b0;
      step(1);
      check("seed_passthrough", eng_vectors_in, {mkvec(16'h5eed), mkvec(16'h0001)});

      // Nominal two-component run with a 50-cycle deflation stall.
      eng_vector_out = vec_a; eng_k = 32'd5; delay_cfg = 20;
      start = 1'b1; n = cyc + 1;
      exp_q.push_back(mk(EV_CAP, 0, vec_a, 32'd5, 1'b0, '0, n + 23));
      exp_q.push_back(mk(EV_DEFL, 0, '0, 32'd0, 1'b0, '0, n + 23));
      step(1);
      check("start_to_eng_rst", CW'({eng_rst, eng_start, busy}), CW'(3'b101));
      step(1);
      check("eng_rst_to_run", CW'({eng_rst, eng_start, busy}), CW'(3'b011));
      step(22);
      stall_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (!(defl_req === 1'b1 && eng_rst === 1'b0)) stall_ok = 1'b0;
         step(1);
      end
      check("deflate_stall", CW'(stall_ok), CW'(1'b1));
      eng_vector_out = vec_b; eng_k = 32'd7; defl_ack = 1'b1; d = cyc + 1;
      exp_q.push_back(mk(EV_CAP, 1, vec_b, 32'd7, 1'b0, '0, d + 23));
      exp_q.push_back(mk(EV_DONE, 0, '0, 32'd0, 1'b0, 2'b11, d + 23));
      step(1);
      defl_ack = 1'b0;
      check("ack_to_eng_rst", CW'({eng_rst, defl_req, busy}), CW'(3'b101));
      drain("nominal_drain", 100);
      check("nominal_components", components, {vec_b, vec_a});
      check("nominal_iters", CW'(comp_iters), CW'({32'd7, 32'd5}));
      check("nominal_done_state", CW'({f, err, busy, comp_valid}), CW'(5'b10011));
      start = 1'b0;
      step(1);
      check("done_to_idle", CW'({f, busy, comp_valid}), CW'(4'b0011));

      // Re-run that times out: flags clear on entry, results survive.
      delay_cfg = 1000; start = 1'b1; n = cyc + 1;
      exp_q.push_back(mk(EV_DONE, 0, '0, 32'd0, 1'b1, 2'b00, n + 65));
      step(1);
      check("rerun_clears", CW'({comp_valid, comp_iters, eng_rst}), CW'({2'b00, 64'd0, 1'b1}));
      drain("timeout_drain", 100);
      check("timeout_keeps_components", components, {vec_b, vec_a});
      start = 1'b0;
      step(1);
      check("timeout_f_drops", CW'({f, busy}), '0);

      // Engine finishes on the very cycle the watchdog expires.
      eng_vector_out = vec_c; eng_k = 32'd9; delay_cfg = 63; start = 1'b1; n = cyc + 1;
      exp_q.push_back(mk(EV_CAP, 0, vec_c, 32'd9, 1'b0, '0, n + 66));
      exp_q.push_back(mk(EV_DEFL, 0, '0, 32'd0, 1'b0, '0, n + 66));
      drain("simul_drain", 150);
      check("simul_no_err", CW'({err, defl_req}), CW'(2'b01));
      eng_vector_out = vec_d; eng_k = 32'd11; delay_cfg = 3; defl_ack = 1'b1; d = cyc + 1;
      exp_q.push_back(mk(EV_CAP, 1, vec_d, 32'd11, 1'b0, '0, d + 6));
      exp_q.push_back(mk(EV_DONE, 0, '0, 32'd0, 1'b0, 2'b11, d + 6));
      step(1);
      defl_ack = 1'b0;
      drain("simul_second_drain", 50);
      start = 1'b0;
      step(1);

      // Reset in the 10th RUN cycle, then a clean restart.
      delay_cfg = 1000; start = 1'b1;
      step(11);
      rst = 1'b1; start = 1'b0;
      step(1);
      check_all_zero("mid_run_reset");
      rst = 1'b0;
      step(1);
      eng_vector_out = vec_a; eng_k = 32'd5; delay_cfg = 2; start = 1'b1; n = cyc + 1;
      exp_q.push_back(mk(EV_CAP, 0, vec_a, 32'd5, 1'b0, '0, n + 5));
      exp_q.push_back(mk(EV_DEFL, 0, '0, 32'd0, 1'b0, '0, n + 5));
      drain("restart_drain", 50);
      eng_vector_out = vec_b; eng_k = 32'd7; defl_ack = 1'b1; d = cyc + 1;
      exp_q.push_back(mk(EV_CAP, 1, vec_b, 32'd7, 1'b0, '0, d + 5));
      exp_q.push_back(mk(EV_DONE, 0, '0, 32'd0, 1'b0, 2'b11, d + 5));
      step(1);
      defl_ack = 1'b0;
      drain("restart_second_drain", 50);
      check("restart_components", components, {vec_b, vec_a});
      start = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/eigen_sequencer.md
# eigen_sequencer

Top-level controller that runs the shared `eigenloop` power-iteration engine once per principal component, for NUM_COMP components in turn. For each component it resets and starts the engine, applies a cycle watchdog, and captures the converged vector and its iteration count. Between components it performs a request/acknowledge handshake with the external matrix-deflation block. It sits between the fetal-ECG separation top level and the single `eigenloop` instance.

## Interface
Parameters:
- SIZE_N, 8, vector length / matrix dimension.
- NUM_COMP, 2, number of components to extract (1..8).
- TIMEOUT, 4096, maximum cycles allowed per engine run before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled only in IDLE.
- seed_vectors  in  double[2][SIZE_N][1]  initial vector pair, reused for every component.
- eng_rst  out  1  reset to the engine.
- eng_start  out  1  start to the engine.
- eng_vectors_in  out  double[2][SIZE_N][1]  vectors driven to the engine.
- eng_vector_out  in  double[SIZE_N][1]  engine result.
- eng_k  in  integer  engine iteration count.
- eng_f  in  1  engine finished.
- defl_req  out  1  requests deflation of the matrix by the component just captured.
- defl_idx  out  3  index of the component to deflate.
- defl_ack  in  1  deflation done; matrix at the engine input is updated.
- components  out  double[NUM_COMP][SIZE_N][1]  captured eigenvectors.
- comp_iters  out  integer[NUM_COMP]  eng_k recorded at capture.
- comp_valid  out  NUM_COMP  per-component captured flag.
- busy  out  1  high in any state except IDLE and DONE.
- err  out  1  watchdog expired.
- f  out  1  sequence complete (with or without error).

## Operation
- Reset state of all outputs: 0, including components, comp_iters, comp_valid, err and f. The state machine returns to IDLE and all counters clear.
- eng_vectors_in = seed_vectors at all times.
- States and transitions:
  - IDLE: if start=1, go to ENG_RST with comp_idx=0.
  - ENG_RST: eng_rst=1 for exactly 1 cycle; the watchdog clears. Go to RUN.
  - RUN: eng_start=1; the watchdog increments every cycle.
    - eng_f=1: go to CAPTURE.
    - Otherwise, if watchdog reaches TIMEOUT-1: set err=1 and go to DONE.
    - eng_f takes priority over timeout in the same cycle.
  - CAPTURE (1 cycle): write components[comp_idx] = eng_vector_out, comp_iters[comp_idx] = eng_k, and set comp_valid[comp_idx] = 1.
    - If comp_idx = NUM_COMP-1: go to DONE.
    - Otherwise: go to DEFLATE.
  - DEFLATE: defl_req=1 and defl_idx=comp_idx, both registered. They stay high until a cycle where defl_req=1 and defl_ack=1 together. Then defl_req drops, comp_idx increments, and the FSM goes to ENG_RST.
  - DONE: f=1. Outputs hold. When start=0, go to IDLE; f drops, and components and comp_valid are retained.
- eng_start is low in every state except RUN. Holding eng_start low in ENG_RST keeps the engine in its initialising state.
- start is ignored outside IDLE. Deasserting it mid-sequence does not abort.
- defl_ack is ignored outside DEFLATE and when defl_req=0.
- On a new run (IDLE→ENG_RST): comp_valid, err and comp_iters clear. components are overwritten as each is captured.
- rst mid-operation: all state clears immediately, including outputs.
- The watchdog is a clog2(TIMEOUT)-bit counter and saturates; it never wraps.

## Timing
- start high in IDLE at edge n gives eng_rst=1 in cycle n+1 and eng_start=1 from cycle n+2.
- eng_f high at edge m gives a capture write at edge m+1, visible at m+2. defl_req=1 from cycle m+2.
- defl_ack accepted at edge d gives eng_rst=1 in cycle d+1.
- Overhead per component, excluding engine and deflation time: 3 cycles (ENG_RST, CAPTURE, DEFLATE handshake edge).
- f asserts the cycle after the last CAPTURE, or the cycle after a timeout.

## Structure
- Package `fsm_eigen_sequencer` holds the state enum: IDLE_ES, ENG_RST_ES, RUN_ES, CAPTURE_ES, DEFLATE_ES, DONE_ES, XXX_ES.
- `double` comes from `fp_double`.
- One sub-module, `seq_watchdog`: clear, enable, saturating counter, and an `expired` output at TIMEOUT-1.
- FSM style: two processes, combinational next-state plus registered state.

## Test plan
- Nominal, NUM_COMP=2: the engine model asserts eng_f after 20 cycles with vectors A then B and eng_k=5 then 7.
  - Required: components = {A, B}, comp_iters = {5, 7}, comp_valid = 2'b11.
  - Exactly one defl_req pulse, with defl_idx=0.
  - f=1 and err=0.
- Deflation stall: hold defl_ack=0 for 50 cycles.
  - Required: defl_req stays high all 50 cycles and eng_rst stays low.
  - eng_rst fires 1 cycle after the ack.
- Timeout, TIMEOUT=64: eng_f is never asserted.
  - Required: err=1 and f=1 in cycle 66 after start, with comp_valid=0.
- Simultaneous events: eng_f arrives on the same edge the watchdog expires.
  - Required: the component is captured and err=0.
- Reset mid-RUN: assert rst in the 10th RUN cycle.
  - Required: all outputs 0 on the next cycle, and the sequence restarts cleanly on the next start.
- Re-run: drop start after DONE, then raise it again.
  - Required: comp_valid clears on re-entry and f drops while start is low.
